uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one codificador_UART transmitter among N requesters, using round-robin arbitration.
- Captures the winning byte and stop-bit mode into a holding register, then drives the encoder's dado / dado_valido / stop_1_2 inputs.
- Sequences each frame by watching the encoder's transmitindo / fim outputs.
- Returns a per-requester completion or error pulse.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, $clog2(N), width of requester index.
- TIMEOUT, 32, max cycles from grant to fim before the frame is abandoned (≥ 16).

Ports:
- clk  in  1  system clock, one UART bit period per cycle.
- reset  in  1  synchronous, active-high.
- req_valid  in  N  requester i has a byte pending; held until req_ack[i].
- req_data  in  N*8  byte of requester i at [8*i+7:8*i].
- req_stop2  in  N  requester i wants 2 stop bits.
- req_ack  out  N  one-cycle pulse: request i captured; requester may drop/change inputs.
- done  out  N  one-cycle pulse: frame of requester i fully transmitted.
- err  out  N  one-cycle pulse: frame of requester i abandoned on timeout.
- busy  out  1  high from grant until return to ARB.
- active_id  out  IDW  index of the current/last granted requester.
- tx_dado  out  8  to encoder dado; held stable for the entire frame.
- tx_dado_valido  out  1  to encoder dado_valido.
- tx_stop_1_2  out  1  to encoder stop_1_2; held stable for the entire frame.
- tx_transmitindo  in  1  from encoder transmitindo.
- tx_fim  in  1  from encoder fim.

Behaviour:
- All outputs are registered.
- Reset values: req_ack=0, done=0, err=0, busy=0, active_id=0, tx_dado=0, tx_dado_valido=0, tx_stop_1_2=0, state=ARB, rr pointer=N-1 (requester 0 has highest priority first). A single timeout counter is also reset to 0.
- Reset mid-frame: everything returns to reset values next edge and no done/err is issued. The encoder shares the reset.
- States: ARB, START_WAIT, FIM_WAIT, STOP2_WAIT.
- ARB, any req_valid: the winner is the first set bit searching from pointer+1 upward, modulo N. At the edge:
  - capture req_data/req_stop2 into tx_dado/tx_stop_1_2;
  - set active_id, pointer:=winner, req_ack[winner]=1 for one cycle;
  - tx_dado_valido:=1, busy:=1, counter:=0;
  - go to START_WAIT.
- ARB, no request: outputs hold; tx_dado_valido=0, busy=0.
- START_WAIT: tx_dado_valido stays 1. When tx_transmitindo=1, tx_dado_valido:=0 and go to FIM_WAIT.
- FIM_WAIT: when tx_fim=1:
  - if tx_stop_1_2=1, go to STOP2_WAIT;
  - otherwise done[active_id]:=1, busy:=0, go to ARB.
- STOP2_WAIT: unconditionally done[active_id]:=1, busy:=0, go to ARB.
- tx_dado_valido is always 0 during stop bits, so the encoder returns to AGUARDA_DADO. There is no back-to-back chaining.
- Timing, grant edge at end of cycle A:
  - req_ack and tx_dado_valido are high in cycle A+1;
  - encoder GERA_START in A+2;
  - TRANS_DADO in A+3..A+10, parity in A+11, STOP1 (fim) in A+12;
  - done in A+13 (1 stop) or A+14 (2 stops).
  - Earliest next grant edge is at the end of the done cycle, giving a frame period of 13 or 14 cycles.
- Timeout: the counter increments every cycle in START_WAIT/FIM_WAIT. When it reaches TIMEOUT-1 without the required event:
  - tx_dado_valido:=0, err[active_id]:=1, busy:=0;
  - go to ARB; the pointer still advances.
- Simultaneous tx_fim and timeout: tx_fim wins.
- Requests arriving outside ARB wait. req_valid is sampled only in ARB, so there is no double ack.
- A requester dropping req_valid before ack is simply not granted.
- At most one bit of each of req_ack, done, err is set at any time.
- done and req_ack never coincide for the same index in one cycle.

Test Plan:
- Single request: req_valid[2]=1, data 8'hA5, stop2=0 → ack[2] at A+1; TX line shows 0, then 1,0,1,0,0,1,0,1 (LSB first), parity 0, stop 1; done[2] at A+13.
- Two stop bits: req 0, data 8'h0F, stop2=1 → parity 0; TX high for two cycles after parity; done[0] at A+14; tx_stop_1_2=1 throughout.
- Round-robin fairness: req_valid=4'b1111 held, each requester re-asserts after ack → grant order 0,1,2,3,0. Each tx_dado equals the corresponding byte, stable from grant to done.
- Stall/timeout: encoder replaced by a model that never raises transmitindo → err[1] pulses exactly TIMEOUT cycles after grant; tx_dado_valido=0 after; next request is served normally.
- Reset mid-frame: assert reset during the TRANS_DADO bit 4 → next cycle all outputs 0, no done; after release, pending req 3 is granted before req 0 only if req 0 is absent (pointer back to N-1).
- Request while busy: req 1 raised during req 0's data bits → no ack until the cycle after done[0]; ack[1] arrives in the same cycle as ARB+1.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART encoder among N requesters.
// Captures the winning byte, sequences the frame, and reports done/err per requester.
module uart_tx_arbiter #(
  parameter int N       = 4,
  parameter int IDW     = $clog2(N),
  parameter int TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req_valid,
  input  logic [N*8-1:0]   req_data,
  input  logic [N-1:0]     req_stop2,
  output logic [N-1:0]     req_ack,
  output logic [N-1:0]     done,
  output logic [N-1:0]     err,
  output logic             busy,
  output logic [IDW-1:0]   active_id,
  output logic [7:0]       tx_dado,
  output logic             tx_dado_valido,
  output logic             tx_stop_1_2,
  input  logic             tx_transmitindo,
  input  logic             tx_fim
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    ARB,
    START_WAIT,
    FIM_WAIT,
    STOP2_WAIT
  } state_t;

  state_t         state, state_n;
  logic [IDW-1:0] ptr, ptr_n;
  logic [CW-1:0]  cnt, cnt_n;

  logic [N-1:0]   ack_n, done_n, err_n;
  logic           busy_n, dv_n, stop_n;
  logic [IDW-1:0] id_n;
  logic [7:0]     dado_n;

  logic           found;
  logic [IDW-1:0] win;
  logic           tmo;

  // first pending requester after the pointer, wrapping modulo N
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  // last waiting cycle: one more miss means TIMEOUT cycles since grant
  assign tmo = (cnt == CW'(TIMEOUT - 2));

  // next state and next values of every registered output
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    cnt_n   = cnt;
    ack_n   = '0;
    done_n  = '0;
    err_n   = '0;
    busy_n  = busy;
    id_n    = active_id;
    dado_n  = tx_dado;
    dv_n    = tx_dado_valido;
    stop_n  = tx_stop_1_2;
    unique case (state)
      ARB: begin
        if (found) begin
          dado_n     = req_data[8*int'(win) +: 8];
          stop_n     = req_stop2[win];
          id_n       = win;
          ptr_n      = win;
          ack_n[win] = 1'b1;
          dv_n       = 1'b1;
          busy_n     = 1'b1;
          cnt_n      = '0;
          state_n    = START_WAIT;
        end else begin
          dv_n   = 1'b0;
          busy_n = 1'b0;
        end
      end
      START_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (tx_transmitindo) begin
          dv_n    = 1'b0;
          state_n = FIM_WAIT;
        end else if (tmo) begin
          dv_n             = 1'b0;
          err_n[active_id] = 1'b1;
          busy_n           = 1'b0;
          state_n          = ARB;
        end
      end
      FIM_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (tx_fim) begin
          if (tx_stop_1_2) begin
            state_n = STOP2_WAIT;
          end else begin
            done_n[active_id] = 1'b1;
            busy_n            = 1'b0;
            state_n           = ARB;
          end
        end else if (tmo) begin
          dv_n             = 1'b0;
          err_n[active_id] = 1'b1;
          busy_n           = 1'b0;
          state_n          = ARB;
        end
      end
      STOP2_WAIT: begin
        done_n[active_id] = 1'b1;
        busy_n            = 1'b0;
        state_n           = ARB;
      end
      default: state_n = ARB;
    endcase
  end

  // state, pointer, counter and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARB;
      ptr            <= IDW'(N - 1);
      cnt            <= '0;
      req_ack        <= '0;
      done           <= '0;
      err            <= '0;
      busy           <= 1'b0;
      active_id      <= '0;
      tx_dado        <= '0;
      tx_dado_valido <= 1'b0;
      tx_stop_1_2    <= 1'b0;
    end else begin
      state          <= state_n;
      ptr            <= ptr_n;
      cnt            <= cnt_n;
      req_ack        <= ack_n;
      done           <= done_n;
      err            <= err_n;
      busy           <= busy_n;
      active_id      <= id_n;
      tx_dado        <= dado_n;
      tx_dado_valido <= dv_n;
      tx_stop_1_2    <= stop_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench with a frame-timeline reference model.
// A small encoder model drives transmitindo/fim and the serial line.
module tb_uart_tx_arbiter;

  localparam int N       = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 32;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]   req_stop2;
  logic [N-1:0]   req_ack, done, err;
  logic           busy;
  logic [IDW-1:0] active_id;
  logic [7:0]     tx_dado;
  logic           tx_dado_valido, tx_stop_1_2;
  logic           tx_transmitindo, tx_fim;
  logic           tx_line;

  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  bit  mon_en = 0;
  bit  hold_mode = 0;
  bit  stall = 0;

  uart_tx_arbiter #(.N(N), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_stop2(req_stop2),
    .req_ack(req_ack),
    .done(done),
    .err(err),
    .busy(busy),
    .active_id(active_id),
    .tx_dado(tx_dado),
    .tx_dado_valido(tx_dado_valido),
    .tx_stop_1_2(tx_stop_1_2),
    .tx_transmitindo(tx_transmitindo),
    .tx_fim(tx_fim)
  );

  always #5 clk = ~clk;

  // encoder model: 0 idle, 1 start, 2..9 data, 10 parity, 11 stop1, 12 stop2
  int         enc_st = 0;
  logic [7:0] enc_d = '0;
  logic       enc_s2 = 1'b0;

  always @(posedge clk) begin
    if (reset) enc_st <= 0;
    else begin
      case (enc_st)
        0: if (tx_dado_valido && !stall) begin
             enc_st <= 1;
             enc_d  <= tx_dado;
             enc_s2 <= tx_stop_1_2;
           end
        11: enc_st <= enc_s2 ? 12 : 0;
        12: enc_st <= 0;
        default: enc_st <= enc_st + 1;
      endcase
    end
  end

  always_comb begin
    tx_line         = 1'b1;
    tx_transmitindo = (enc_st >= 1) && (enc_st <= 10);
    tx_fim          = (enc_st == 11);
    if (enc_st == 1) tx_line = 1'b0;
    else if (enc_st >= 2 && enc_st <= 9) tx_line = enc_d[enc_st-2];
    else if (enc_st == 10) tx_line = ^enc_d;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h",
               name, cyc, got, exp);
    end
  endtask

  // reference model: each frame is a timeline of offsets from its grant cycle
  int         cyc_m = 0;
  bit         in_frame = 0;
  int         fa = 0, fw = 0, flen = 13;
  bit         fstall = 0;
  logic [7:0] fdata = '0;
  logic       fstop = 1'b0;
  int         mid = 0, mptr = N - 1;

  always @(negedge clk) begin
    int d, w;
    logic [N-1:0] e_ack, e_done, e_err;
    logic e_dv, e_busy;
    cyc_m++;
    d = cyc_m - fa;
    e_ack = '0; e_done = '0; e_err = '0;
    e_dv = 1'b0; e_busy = 1'b0;
    if (in_frame) begin
      if (d == 1) e_ack[fw] = 1'b1;
      e_busy = (d >= 1) && (d < flen);
      e_dv = fstall ? ((d >= 1) && (d < flen)) : ((d == 1) || (d == 2));
      if (d == flen) begin
        if (fstall) e_err[fw] = 1'b1;
        else e_done[fw] = 1'b1;
      end
    end
    if (mon_en) begin
      chk("req_ack", req_ack, e_ack);
      chk("done", done, e_done);
      chk("err", err, e_err);
      chk("busy", busy, e_busy);
      chk("tx_dado_valido", tx_dado_valido, e_dv);
      chk("active_id", active_id, mid);
      chk("tx_dado", tx_dado, fdata);
      chk("tx_stop_1_2", tx_stop_1_2, fstop);
    end
    if (reset) begin
      in_frame = 0; mptr = N - 1; mid = 0; fdata = '0; fstop = 1'b0;
    end else if (!in_frame || d >= flen) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req_valid[(mptr + k) % N]) w = (mptr + k) % N;
      if (w >= 0) begin
        in_frame = 1; fa = cyc_m; fw = w; mid = w; mptr = w;
        fdata = req_data[8*w +: 8];
        fstop = req_stop2[w];
        fstall = stall;
        flen = stall ? TIMEOUT : (fstop ? 14 : 13);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (req_ack[i] === 1'b1) begin
        if (hold_mode) req_data[8*i +: 8] = req_data[8*i +: 8] + 8'h11;
        else req_valid[i] = 1'b0;
      end
  endtask

  // kind: 0 ack, 1 done, 2 err
  task automatic wait_sig(input int kind, input int idx, input int budget,
                          output int t);
    bit hit;
    hit = 0;
    t = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      tick();
      case (kind)
        0: hit = req_ack[idx];
        1: hit = done[idx];
        default: hit = err[idx];
      endcase
      if (hit) t = cyc;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL wait kind %0d idx %0d: got none expected pulse in %0d",
               kind, idx, budget);
    end
  endtask

  task automatic request(input int i, input logic [7:0] b, input logic s2);
    req_data[8*i +: 8] = b;
    req_stop2[i] = s2;
    req_valid[i] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int ta, td, te, t2;
    logic [10:0] line11, exp11;
    logic [11:0] line12, exp12;
    logic [N-1:0] seen;
    int got_ord;
    int exp_ord [5];
    exp_ord = '{0, 1, 2, 3, 0};
    reset = 1'b1; req_valid = '0; req_data = '0; req_stop2 = '0;
    tick(); tick();
    reset = 1'b0;
    mon_en = 1;
    chk("reset busy", busy, 0);
    chk("reset ack", req_ack, 0);
    chk("reset dado", tx_dado, 0);
    chk("reset id", active_id, 0);

    // single request, 1 stop bit
    request(2, 8'hA5, 1'b0);
    wait_sig(0, 2, 8, ta);
    for (int k = 0; k < 11; k++) begin tick(); line11[k] = tx_line; end
    exp11 = 11'b10101001010;
    chk("line A5", line11, exp11);
    wait_sig(1, 2, 4, td);
    chk("done2 latency", td - ta, 12);

    // two stop bits
    request(0, 8'h0F, 1'b1);
    wait_sig(0, 0, 8, ta);
    for (int k = 0; k < 12; k++) begin tick(); line12[k] = tx_line; end
    exp12 = 12'b110000011110;
    chk("line 0F", line12, exp12);
    wait_sig(1, 0, 4, td);
    chk("done0 latency", td - ta, 13);

    // stalled encoder: timeout
    stall = 1;
    request(1, 8'h3C, 1'b0);
    wait_sig(0, 1, 8, ta);
    wait_sig(2, 1, 64, te);
    chk("err latency", te - ta, TIMEOUT - 1);
    chk("dv at err", tx_dado_valido, 0);
    stall = 0;
    request(3, 8'h77, 1'b0);
    wait_sig(0, 3, 8, ta);
    wait_sig(1, 3, 20, td);
    chk("post-stall latency", td - ta, 12);

    // request while busy
    request(0, 8'h81, 1'b0);
    wait_sig(0, 0, 8, ta);
    repeat (4) tick();
    request(1, 8'h5A, 1'b0);
    wait_sig(1, 0, 20, td);
    wait_sig(0, 1, 8, t2);
    chk("ack1 after done0", t2 - td, 1);
    wait_sig(1, 1, 20, td);

    // reset during data bit 4
    request(2, 8'hE7, 1'b0);
    wait_sig(0, 2, 8, ta);
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("mid-reset busy", busy, 0);
    chk("mid-reset done", done, 0);
    chk("mid-reset dado", tx_dado, 0);
    chk("mid-reset dv", tx_dado_valido, 0);
    chk("mid-reset id", active_id, 0);
    reset = 1'b0;
    seen = '0;
    repeat (16) begin tick(); seen |= done; end
    chk("no done after reset", seen, 0);
    request(0, 8'h12, 1'b0);
    request(3, 8'h34, 1'b0);
    tick();
    chk("ptr restored prio", req_ack, 4'b0001);
    wait_sig(1, 0, 20, td);
    wait_sig(0, 3, 8, ta);
    wait_sig(1, 3, 20, td);

    // round-robin fairness with all requesters held
    hold_mode = 1;
    for (int i = 0; i < N; i++) request(i, 8'hC0 + 8'(i), 1'(i % 2));
    for (int g = 0; g < 5; g++) begin
      got_ord = -1;
      for (int c = 0; c < 8 && got_ord < 0; c++) begin
        tick();
        for (int i = 0; i < N; i++) if (req_ack[i]) got_ord = i;
      end
      chk("grant order", got_ord, exp_ord[g]);
      if (got_ord < 0) break;
      wait_sig(1, got_ord, 20, td);
    end
    req_valid = '0;
    hold_mode = 0;
    repeat (4) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
